// File: rtl/kernel_launch_if.sv
// Host-request, dispatcher-control and status bundle for the kernel launch sequencer.
interface kernel_launch_if #(
  parameter int DEPTH = 4
);
  localparam int PW = $clog2(DEPTH) + 1;

  logic          req_valid;
  logic          req_ready;
  logic [7:0]    req_thread_count;
  logic          dispatch_reset;
  logic          dispatch_start;
  logic [7:0]    dispatch_thread_count;
  logic          dispatch_done;
  logic          kernel_done;
  logic          kernel_error;
  logic          busy;
  logic [PW-1:0] pending;
  logic [31:0]   last_cycles;
  logic [15:0]   completed;

  modport master (
    output req_valid, req_thread_count, dispatch_done,
    input  req_ready, dispatch_reset, dispatch_start, dispatch_thread_count,
    input  kernel_done, kernel_error, busy, pending, last_cycles, completed
  );

  modport slave (
    input  req_valid, req_thread_count, dispatch_done,
    output req_ready, dispatch_reset, dispatch_start, dispatch_thread_count,
    output kernel_done, kernel_error, busy, pending, last_cycles, completed
  );
endinterface

// File: rtl/kernel_launch.sv
// Launch FIFO plus sequencer that runs each queued kernel through the dispatcher
// (clear, start, wait for done or watchdog, retire) and reports per-kernel run cycles.
module kernel_launch #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 65535
) (
  input logic            clk,
  input logic            reset,
  kernel_launch_if.slave bus
);
  localparam int              AW          = $clog2(DEPTH);
  localparam int              CW          = AW + 1;
  localparam logic [CW-1:0]   FULL_CNT    = CW'(DEPTH);
  localparam logic [31:0]     TIMEOUT_CNT = 32'(TIMEOUT);
  localparam bit              WD_EN       = (TIMEOUT != 0);

  typedef enum logic [1:0] {IDLE, CLEAR, RUN, RETIRE} state_t;

  state_t        state, state_next;
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          full, empty, push, pop;
  logic [7:0]    head;

  logic [7:0]    thread_cnt, thread_cnt_next;
  logic          dreset, dreset_next;
  logic          dstart, dstart_next;
  logic          kdone, kdone_next;
  logic          kerr, kerr_next;
  logic [31:0]   last_cyc, last_cyc_next;
  logic [15:0]   done_cnt, done_cnt_next;
  logic [31:0]   run_cnt, run_cnt_next;
  logic [31:0]   run_inc;

  // Ready depends on occupancy alone, so a full FIFO refuses a push even while popping.
  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);
  assign push  = bus.req_valid && !full;
  assign head  = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus.req_thread_count;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end

  assign run_inc = run_cnt + 32'd1;

  always_comb begin
    state_next      = state;
    pop             = 1'b0;
    thread_cnt_next = thread_cnt;
    dreset_next     = 1'b0;
    dstart_next     = 1'b0;
    kdone_next      = 1'b0;
    kerr_next       = 1'b0;
    last_cyc_next   = last_cyc;
    done_cnt_next   = done_cnt;
    run_cnt_next    = run_cnt;
    unique case (state)
      IDLE: begin
        if (!empty) begin
          pop             = 1'b1;
          thread_cnt_next = head;
          // A zero-thread kernel would never see done, so it retires without touching the dispatcher.
          if (head == 8'd0) begin
            state_next    = RETIRE;
            kdone_next    = 1'b1;
            last_cyc_next = 32'd0;
            done_cnt_next = done_cnt + 16'd1;
            run_cnt_next  = 32'd0;
          end else begin
            state_next  = CLEAR;
            dreset_next = 1'b1;
          end
        end
      end
      CLEAR: begin
        state_next   = RUN;
        dstart_next  = 1'b1;
        run_cnt_next = 32'd0;
      end
      RUN: begin
        run_cnt_next = run_inc;
        if (bus.dispatch_done) begin
          state_next    = RETIRE;
          kdone_next    = 1'b1;
          last_cyc_next = run_inc;
          done_cnt_next = done_cnt + 16'd1;
        end else if (WD_EN && (run_inc == TIMEOUT_CNT)) begin
          // Aborted kernels also reset the dispatcher so the next launch starts clean.
          state_next    = RETIRE;
          kdone_next    = 1'b1;
          kerr_next     = 1'b1;
          dreset_next   = 1'b1;
          last_cyc_next = run_inc;
          done_cnt_next = done_cnt + 16'd1;
        end else begin
          dstart_next = 1'b1;
        end
      end
      RETIRE: begin
        state_next   = IDLE;
        run_cnt_next = 32'd0;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      thread_cnt <= 8'd0;
      dreset     <= 1'b1;
      dstart     <= 1'b0;
      kdone      <= 1'b0;
      kerr       <= 1'b0;
      last_cyc   <= 32'd0;
      done_cnt   <= 16'd0;
      run_cnt    <= 32'd0;
    end else begin
      state      <= state_next;
      thread_cnt <= thread_cnt_next;
      dreset     <= dreset_next;
      dstart     <= dstart_next;
      kdone      <= kdone_next;
      kerr       <= kerr_next;
      last_cyc   <= last_cyc_next;
      done_cnt   <= done_cnt_next;
      run_cnt    <= run_cnt_next;
    end
  end

  assign bus.req_ready             = !full;
  assign bus.busy                  = (state != IDLE) || !empty;
  assign bus.pending               = count;
  assign bus.dispatch_reset        = dreset;
  assign bus.dispatch_start        = dstart;
  assign bus.dispatch_thread_count = thread_cnt;
  assign bus.kernel_done           = kdone;
  assign bus.kernel_error          = kerr;
  assign bus.last_cycles           = last_cyc;
  assign bus.completed             = done_cnt;
endmodule

// File: tb/tb_kernel_launch.sv
// Directed bench for kernel_launch: a vector table of single kernels plus hand-written
// sequences for backpressure, zero-count, start drop, watchdog abort and reset mid-run.
module tb_kernel_launch;
  logic clk = 1'b0;
  logic rst_n;
  logic wrst_n;
  always #5 clk = ~clk;

  kernel_launch_if #(.DEPTH(4)) bus ();
  kernel_launch_if #(.DEPTH(4)) wbus ();

  kernel_launch #(.DEPTH(4), .TIMEOUT(65535)) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus.slave)
  );

  kernel_launch #(.DEPTH(4), .TIMEOUT(16)) wdut (
    .clk   (clk),
    .reset (wrst_n),
    .bus   (wbus.slave)
  );

  typedef struct {
    logic [7:0]  tc;
    int          delay;
    logic [31:0] exp_last;
  } vec_t;

  vec_t vecs[4];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   exp_done;
  int   starts, got, cyc;
  int   gap, low, resets, rises_rst, kdones;
  logic fell, prev_start, prev_rst;
  logic [7:0] tc_seen;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] tc);
    bus.req_valid        = 1'b1;
    bus.req_thread_count = tc;
    tick();
    bus.req_valid        = 1'b0;
  endtask

  // Dispatcher stand-in: raises done once start has been high for d sampled cycles.
  task automatic serve(input int d, output logic [7:0] tc, output int ok);
    int run;
    run = 0;
    ok  = 0;
    tc  = 8'hxx;
    for (int k = 0; k < 60 && ok == 0; k++) begin
      if (bus.dispatch_start) begin
        run++;
        if (run >= d) bus.dispatch_done = 1'b1;
      end
      tick();
      if (bus.kernel_done) begin
        ok = 1;
        tc = bus.dispatch_thread_count;
        bus.dispatch_done = 1'b0;
      end
    end
    bus.dispatch_done = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: got 1, expected 0");
    $fatal(1, "bench stalled");
  end

  initial begin
    vecs[0] = '{8'd8,   20, 32'd20};
    vecs[1] = '{8'd3,   1,  32'd1};
    vecs[2] = '{8'd200, 5,  32'd5};
    vecs[3] = '{8'd255, 2,  32'd2};

    bus.req_valid = 1'b0;  bus.req_thread_count = 8'd0;  bus.dispatch_done = 1'b0;
    wbus.req_valid = 1'b0; wbus.req_thread_count = 8'd0; wbus.dispatch_done = 1'b0;
    rst_n = 1'b0;
    wrst_n = 1'b0;
    tick();
    tick();

    // Reset state
    check("rst_pending", bus.pending, 0);
    check("rst_ready", bus.req_ready, 1);
    check("rst_dreset", bus.dispatch_reset, 1);
    check("rst_start", bus.dispatch_start, 0);
    check("rst_tc", bus.dispatch_thread_count, 0);
    check("rst_kdone", bus.kernel_done, 0);
    check("rst_kerr", bus.kernel_error, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_last", bus.last_cycles, 0);
    check("rst_completed", bus.completed, 0);
    check("wrst_dreset", wbus.dispatch_reset, 1);
    rst_n = 1'b1;
    wrst_n = 1'b1;
    tick();
    check("rel_dreset", bus.dispatch_reset, 0);
    check("rel_busy", bus.busy, 0);

    // Single kernels from the table
    exp_done = 0;
    for (int i = 0; i < 4; i++) begin
      push(vecs[i].tc);
      check("push_pending", bus.pending, 1);
      check("push_busy", bus.busy, 1);
      tick();
      check("clear_dreset", bus.dispatch_reset, 1);
      check("clear_start", bus.dispatch_start, 0);
      check("clear_tc", bus.dispatch_thread_count, vecs[i].tc);
      check("clear_pending", bus.pending, 0);
      tick();
      check("run_start", bus.dispatch_start, 1);
      check("run_dreset", bus.dispatch_reset, 0);
      starts = 1;
      for (int k = 1; k < vecs[i].delay; k++) begin
        tick();
        if (bus.dispatch_start) starts++;
      end
      bus.dispatch_done = 1'b1;
      tick();
      exp_done++;
      check("ret_kdone", bus.kernel_done, 1);
      check("ret_kerr", bus.kernel_error, 0);
      check("ret_start", bus.dispatch_start, 0);
      check("ret_last", bus.last_cycles, vecs[i].exp_last);
      check("ret_completed", bus.completed, exp_done);
      check("start_cycles", starts, vecs[i].exp_last);
      bus.dispatch_done = 1'b0;
      tick();
      check("kdone_pulse", bus.kernel_done, 0);
      check("idle_busy", bus.busy, 0);
    end

    // Fill and backpressure while a kernel runs
    push(8'd10);
    tick();
    tick();
    check("fill_run", bus.dispatch_start, 1);
    for (int i = 1; i <= 4; i++) begin
      bus.req_valid        = 1'b1;
      bus.req_thread_count = 8'(i);
      tick();
    end
    check("full_ready", bus.req_ready, 0);
    check("full_pending", bus.pending, 4);
    bus.req_thread_count = 8'd5;
    tick();
    tick();
    tick();
    check("held_pending", bus.pending, 4);
    bus.dispatch_done = 1'b1;
    tick();
    exp_done++;
    bus.dispatch_done = 1'b0;
    check("fill_kdone", bus.kernel_done, 1);
    check("fill_tc", bus.dispatch_thread_count, 10);
    tick();
    check("idle_full_pending", bus.pending, 4);
    check("idle_full_ready", bus.req_ready, 0);
    tick();
    check("pop_nobypass_pending", bus.pending, 3);
    check("pop_ready", bus.req_ready, 1);
    check("pop_tc", bus.dispatch_thread_count, 1);
    tick();
    bus.req_valid = 1'b0;
    check("fifth_pending", bus.pending, 4);
    for (int i = 1; i <= 5; i++) begin
      serve(1, tc_seen, got);
      check("order_got", got, 1);
      check("order_tc", tc_seen, i);
      exp_done++;
    end
    check("fill_completed", bus.completed, exp_done);
    tick();

    // Zero-count request followed by a normal one
    bus.req_valid        = 1'b1;
    bus.req_thread_count = 8'd0;
    tick();
    check("zero_pre_dreset", bus.dispatch_reset, 0);
    bus.req_thread_count = 8'd4;
    tick();
    bus.req_valid = 1'b0;
    exp_done++;
    check("zero_kdone", bus.kernel_done, 1);
    check("zero_kerr", bus.kernel_error, 0);
    check("zero_last", bus.last_cycles, 0);
    check("zero_dreset", bus.dispatch_reset, 0);
    check("zero_start", bus.dispatch_start, 0);
    check("zero_completed", bus.completed, exp_done);
    serve(3, tc_seen, got);
    exp_done++;
    check("after_zero_got", got, 1);
    check("after_zero_tc", tc_seen, 4);
    check("after_zero_last", bus.last_cycles, 3);
    tick();

    // Start must drop between back-to-back kernels
    bus.req_valid        = 1'b1;
    bus.req_thread_count = 8'd4;
    tick();
    tick();
    bus.req_valid = 1'b0;
    gap = 0; low = 0; resets = 0; rises_rst = 0; kdones = 0;
    fell = 1'b0; prev_start = 1'b0; prev_rst = 1'b0;
    for (int k = 0; k < 30; k++) begin
      if (bus.dispatch_reset) resets++;
      if (bus.kernel_done) kdones++;
      if (bus.dispatch_start && !prev_start && prev_rst) rises_rst++;
      if (!bus.dispatch_start && prev_start) fell = 1'b1;
      if (!bus.dispatch_start && fell) low++;
      if (bus.dispatch_start && fell && gap == 0) gap = low;
      bus.dispatch_done = bus.dispatch_start;
      prev_start = bus.dispatch_start;
      prev_rst   = bus.dispatch_reset;
      tick();
    end
    bus.dispatch_done = 1'b0;
    exp_done += 2;
    check("b2b_kdones", kdones, 2);
    check("b2b_resets", resets, 2);
    check("b2b_reset_before_start", rises_rst, 2);
    check("b2b_start_gap", gap, 3);
    check("b2b_completed", bus.completed, exp_done);

    // Watchdog abort on the TIMEOUT=16 instance, then the queued kernel launches
    wbus.req_valid        = 1'b1;
    wbus.req_thread_count = 8'd7;
    tick();
    wbus.req_thread_count = 8'd9;
    tick();
    wbus.req_valid = 1'b0;
    tick();
    check("wd_start", wbus.dispatch_start, 1);
    cyc = 0;
    got = 0;
    for (int k = 0; k < 40 && got == 0; k++) begin
      tick();
      cyc++;
      if (wbus.kernel_done) got = 1;
    end
    check("wd_got", got, 1);
    check("wd_cycles", cyc, 16);
    check("wd_kerr", wbus.kernel_error, 1);
    check("wd_dreset", wbus.dispatch_reset, 1);
    check("wd_start_low", wbus.dispatch_start, 0);
    check("wd_last", wbus.last_cycles, 16);
    check("wd_tc", wbus.dispatch_thread_count, 7);
    check("wd_completed", wbus.completed, 1);
    tick();
    check("wd_pulse", wbus.kernel_done, 0);
    check("wd_idle_dreset", wbus.dispatch_reset, 0);
    tick();
    check("wd_next_dreset", wbus.dispatch_reset, 1);
    check("wd_next_tc", wbus.dispatch_thread_count, 9);
    tick();
    check("wd_next_start", wbus.dispatch_start, 1);
    wbus.dispatch_done = 1'b1;
    tick();
    wbus.dispatch_done = 1'b0;
    check("wd_next_kdone", wbus.kernel_done, 1);
    check("wd_next_kerr", wbus.kernel_error, 0);
    check("wd_next_last", wbus.last_cycles, 1);

    // Reset asserted mid-RUN with requests still queued
    tick();
    bus.req_valid        = 1'b1;
    bus.req_thread_count = 8'd20;
    tick();
    bus.req_thread_count = 8'd21;
    tick();
    bus.req_thread_count = 8'd22;
    tick();
    bus.req_valid = 1'b0;
    tick();
    tick();
    check("mid_start", bus.dispatch_start, 1);
    check("mid_pending", bus.pending, 2);
    rst_n = 1'b0;
    tick();
    check("mr_start", bus.dispatch_start, 0);
    check("mr_dreset", bus.dispatch_reset, 1);
    check("mr_kdone", bus.kernel_done, 0);
    check("mr_tc", bus.dispatch_thread_count, 0);
    check("mr_pending", bus.pending, 0);
    check("mr_ready", bus.req_ready, 1);
    check("mr_busy", bus.busy, 0);
    check("mr_last", bus.last_cycles, 0);
    check("mr_completed", bus.completed, 0);
    tick();
    rst_n = 1'b1;
    kdones = 0;
    starts = 0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (bus.kernel_done) kdones++;
      if (bus.dispatch_start) starts++;
    end
    check("mr_no_kdone", kdones, 0);
    check("mr_no_start", starts, 0);
    check("mr_after_pending", bus.pending, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
